// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one-cycle-latency imem reads and buffers returned words
// in a DEPTH-entry ring until decode consumes them; flush discards everything.
module fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_valid,
    input  logic [31:0] pc_in,
    output logic        pc_ready,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_misaligned,
    input  logic        instr_ready
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [31:0] NopInstr = 32'h0000_0013;

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic          infl_v_q, infl_v_d;
    logic [31:0]   infl_pc_q, infl_pc_d;
    logic          infl_mis_q, infl_mis_d;

    logic [31:0] mem_instr_q [DEPTH];
    logic [31:0] mem_pc_q    [DEPTH];
    logic        mem_mis_q   [DEPTH];

    logic [CW-1:0] fill;
    logic          wr;
    logic          pop;
    logic [31:0]   wr_instr;

    // Counting the outstanding read guarantees its response always has a free slot.
    assign fill      = count_q + CW'(infl_v_q);
    assign pc_ready  = !reset && (fill < DepthC);
    assign imem_req  = pc_valid && pc_ready && !flush;
    assign imem_addr = {pc_in[31:2], 2'b00};

    assign wr       = infl_v_q && !flush;
    assign pop      = (count_q != '0) && instr_ready && !flush;
    assign wr_instr = infl_mis_q ? NopInstr : imem_rdata;

    assign instr_valid      = (count_q != '0);
    assign instr            = mem_instr_q[head_q];
    assign instr_pc         = mem_pc_q[head_q];
    assign instr_misaligned = mem_mis_q[head_q];

    always_comb begin
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        infl_v_d   = imem_req;
        infl_pc_d  = infl_pc_q;
        infl_mis_d = infl_mis_q;

        if (imem_req) begin
            infl_pc_d  = pc_in;
            infl_mis_d = (pc_in[1:0] != 2'b00);
        end

        if (flush) begin
            count_d  = '0;
            head_d   = '0;
            tail_d   = '0;
            infl_v_d = 1'b0;
        end else begin
            if (wr) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            unique case ({wr, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            infl_v_q   <= 1'b0;
            infl_pc_q  <= '0;
            infl_mis_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_instr_q[i] <= '0;
                mem_pc_q[i]    <= '0;
                mem_mis_q[i]   <= 1'b0;
            end
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            infl_v_q   <= infl_v_d;
            infl_pc_q  <= infl_pc_d;
            infl_mis_q <= infl_mis_d;
            if (wr) begin
                mem_instr_q[tail_q] <= wr_instr;
                mem_pc_q[tail_q]    <= infl_pc_q;
                mem_mis_q[tail_q]   <= infl_mis_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_valid;
    logic [31:0] pc_in;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_misaligned;
    logic        instr_ready;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_valid         (pc_valid),
        .pc_in            (pc_in),
        .pc_ready         (pc_ready),
        .flush            (flush),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .instr_misaligned (instr_misaligned),
        .instr_ready      (instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        mis;
    } ent_t;

    ent_t        q[$];
    bit          m_infl;
    logic [31:0] m_ipc;
    bit          last_req;
    logic [31:0] popped[$];
    int          tests = 0;
    int          fails = 0;
    int          req_cnt;
    int          acc;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a + 32'h100;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit pv, input logic [31:0] pc, input bit fl, input bit rdy);
        pc_valid    = pv;
        pc_in       = pc;
        flush       = fl;
        instr_ready = rdy;
        imem_rdata  = m_infl ? memfn({m_ipc[31:2], 2'b00}) : $urandom;
    endtask

    // Compare DUT outputs against the model at the falling edge.
    task automatic half();
        bit exp_rdy;
        @(negedge clk);
        exp_rdy  = !reset && ((q.size() + int'(m_infl)) < DEPTH);
        last_req = pc_valid && exp_rdy && !flush;
        chk("pc_ready", {31'b0, pc_ready}, {31'b0, exp_rdy});
        chk("imem_req", {31'b0, imem_req}, {31'b0, last_req});
        if (last_req) chk("imem_addr", imem_addr, {pc_in[31:2], 2'b00});
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            chk("instr", instr, q[0].ins);
            chk("instr_pc", instr_pc, q[0].pc);
            chk("instr_misaligned", {31'b0, instr_misaligned}, {31'b0, q[0].mis});
        end
    endtask

    task automatic fin();
        ent_t e;
        @(posedge clk);
        if (flush) begin
            q.delete();
            m_infl = 1'b0;
        end else begin
            if (q.size() != 0 && instr_ready) begin
                popped.push_back(q[0].pc);
                void'(q.pop_front());
            end
            if (m_infl) begin
                e.pc  = m_ipc;
                e.mis = (m_ipc[1:0] != 2'b00);
                e.ins = e.mis ? 32'h13 : memfn({m_ipc[31:2], 2'b00});
                q.push_back(e);
            end
            m_infl = last_req;
            if (last_req) m_ipc = pc_in;
            if (q.size() > DEPTH) chk("model_overflow", q.size(), DEPTH);
        end
        #1;
    endtask

    task automatic cyc(input bit pv, input logic [31:0] pc, input bit fl, input bit rdy);
        drive(pv, pc, fl, rdy);
        half();
        fin();
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * DEPTH && (q.size() != 0 || m_infl); i++) cyc(0, 0, 0, 1);
        chk("drain_empty", q.size() + int'(m_infl), 0);
    endtask

    initial begin
        m_infl = 1'b0;
        m_ipc  = '0;
        reset  = 1'b1;
        drive(1, 32'h10, 0, 1);

        // Reset values, pc_valid held high.
        @(negedge clk);
        chk("rst_pc_ready", {31'b0, pc_ready}, 0);
        chk("rst_imem_req", {31'b0, imem_req}, 0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_mis", {31'b0, instr_misaligned}, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        drive(0, 0, 0, 1);
        @(negedge clk);
        chk("post_rst_ready", {31'b0, pc_ready}, 1);
        @(posedge clk);
        #1;

        // Streaming 0,4,8,12.
        for (int k = 0; k < 6; k++) begin
            drive(k < 4, 32'(4 * k), 0, 1);
            half();
            if (k >= 2) begin
                chk("stream_valid", {31'b0, instr_valid}, 1);
                chk("stream_instr", instr, 32'h100 + 32'(4 * (k - 2)));
                chk("stream_pc", instr_pc, 32'(4 * (k - 2)));
            end else begin
                chk("stream_lat", {31'b0, instr_valid}, 0);
            end
            fin();
        end
        drain();

        // Backpressure.
        req_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1, 32'h40 + 32'(4 * k), 0, 0);
            half();
            if (imem_req) req_cnt++;
            if (k >= 4) chk("bp_ready_low", {31'b0, pc_ready}, 0);
            fin();
        end
        chk("bp_req_count", req_cnt, 4);
        for (int j = 0; j < 4; j++) begin
            drive(1, 32'h80 + 32'(4 * j), 0, 1);
            half();
            chk("bp_drain_instr", instr, 32'h140 + 32'(4 * j));
            if (j == 1) chk("bp_resume", {31'b0, imem_req}, 1);
            fin();
        end
        drain();

        // Flush with two queued and one in flight.
        cyc(1, 32'h300, 0, 0);
        cyc(1, 32'h304, 0, 0);
        cyc(1, 32'h308, 0, 0);
        drive(1, 32'h999, 1, 0);
        half();
        chk("flush_q_level", q.size(), 2);
        chk("flush_no_req", {31'b0, imem_req}, 0);
        fin();
        drive(1, 32'h200, 0, 1);
        half();
        chk("flush_valid0", {31'b0, instr_valid}, 0);
        chk("flush_ready1", {31'b0, pc_ready}, 1);
        fin();
        cyc(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        half();
        chk("flush_new_instr", instr, 32'h300);
        chk("flush_new_pc", instr_pc, 32'h200);
        fin();
        drive(0, 0, 0, 1);
        half();
        chk("flush_sole", {31'b0, instr_valid}, 0);
        fin();

        // Misaligned.
        drive(1, 32'h6, 0, 1);
        half();
        chk("mis_addr", imem_addr, 32'h4);
        fin();
        cyc(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        half();
        chk("mis_instr", instr, 32'h13);
        chk("mis_pc", instr_pc, 32'h6);
        chk("mis_flag", {31'b0, instr_misaligned}, 1);
        fin();
        drain();

        // Wrap with instr_ready toggling.
        popped.delete();
        acc = 0;
        for (int c = 0; c < 60 && acc < 10; c++) begin
            drive(1, 32'h400 + 32'(4 * acc), 0, c[0]);
            half();
            if (last_req) acc++;
            fin();
        end
        chk("wrap_accepted", acc, 10);
        drain();
        chk("wrap_pop_count", popped.size(), 10);
        for (int k = 0; k < 10 && k < popped.size(); k++)
            chk("wrap_order", popped[k], 32'h400 + 32'(4 * k));

        // Async reset with three entries queued.
        cyc(1, 32'h500, 0, 0);
        cyc(1, 32'h504, 0, 0);
        cyc(1, 32'h508, 0, 0);
        drive(0, 0, 0, 0);
        half();
        chk("arst_level", q.size() + int'(m_infl), 3);
        fin();
        #1 reset = 1'b1;
        pc_valid = 1'b1;
        #1;
        chk("arst_valid", {31'b0, instr_valid}, 0);
        chk("arst_ready", {31'b0, pc_ready}, 0);
        chk("arst_req", {31'b0, imem_req}, 0);
        q.delete();
        m_infl = 1'b0;
        @(posedge clk);
        #3 reset = 1'b0;
        drive(1, 32'h600, 0, 1);
        half();
        chk("arst_release_ready", {31'b0, pc_ready}, 1);
        fin();
        drain();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 15) == 0,
                $urandom_range(0, 2) != 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of instruction entries; power of two, minimum 2.
REQ-002 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port pc_valid  input  1  fetch address offered by the PC counter.
REQ-005 The block SHALL have port pc_in  input  32  byte address to fetch.
REQ-006 The block SHALL have port pc_ready  output  1  fetch address accepted this cycle when high with pc_valid.
REQ-007 The block SHALL have port flush  input  1  redirect (branch/jal/jalr) and discard all queued and in-flight fetches.
REQ-008 The block SHALL have port imem_req  output  1  instruction memory read strobe.
REQ-009 The block SHALL have port imem_addr  output  32  word-aligned read address.
REQ-010 The block SHALL have port imem_rdata  input  32  read data, valid exactly one cycle after imem_req.
REQ-011 The block SHALL have port instr_valid  output  1  head entry available to decode.
REQ-012 The block SHALL have port instr  output  32  head instruction word.
REQ-013 The block SHALL have port instr_pc  output  32  address of head instruction.
REQ-014 The block SHALL have port instr_misaligned  output  1  head entry came from a pc_in with pc_in[1:0] != 0.
REQ-015 The block SHALL have port instr_ready  input  1  decode consumes head entry when high with instr_valid.

Function
REQ-016 pc_ready SHALL equal !reset && (count + inflight_v < DEPTH); count = occupied entries, inflight_v = one outstanding read.
REQ-017 imem_req SHALL equal pc_valid && pc_ready && !flush, combinationally; imem_addr SHALL equal {pc_in[31:2], 2'b00}.
REQ-018 On an accepted request, inflight_v SHALL be set next cycle, capturing pc_in and misaligned flag (pc_in[1:0] != 0); otherwise inflight_v clears.
REQ-019 In any cycle with inflight_v=1 and flush=0, an entry {imem_rdata, captured pc, flag} SHALL be written at tail and tail incremented modulo DEPTH.
REQ-020 A misaligned entry SHALL store instr = 32'h00000013 (NOP) instead of imem_rdata.
REQ-021 instr_valid SHALL equal (count != 0); instr, instr_pc, instr_misaligned SHALL reflect the head entry with zero combinational dependence on imem_rdata.
REQ-022 Pop occurs when instr_valid && instr_ready && !flush; head increments modulo DEPTH.
REQ-023 Simultaneous write and pop SHALL leave count unchanged; write alone +1, pop alone -1.
REQ-024 count SHALL never exceed DEPTH; REQ-016 guarantees a slot for every in-flight response.
REQ-025 flush SHALL take priority over all events: next cycle count=0, head=tail=0, inflight_v=0; the response arriving in the flush cycle is dropped; no imem_req in the flush cycle.
REQ-026 The cycle after flush, pc_ready SHALL be 1 and a new pc_in SHALL be accepted normally.
REQ-027 With instr_ready held high and pc_valid held high, throughput SHALL be one instruction per cycle; latency from accept to instr_valid is 2 cycles.
REQ-028 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated entries.

Reset
REQ-029 While reset=1: count=0, head=tail=0, inflight_v=0, all entry storage=0, instr_valid=0, instr=0, instr_pc=0, instr_misaligned=0, pc_ready=0, imem_req=0.
REQ-030 Reset asserted mid-operation SHALL discard queued and in-flight fetches immediately, without waiting for a clock edge.
REQ-031 First cycle after reset release: pc_ready=1.

Verification
REQ-032 Streaming: pc_in 0,4,8,12 on consecutive cycles, imem_rdata = addr+0x100, instr_ready=1 -> instr_valid from cycle 2; instr 0x100,0x104,0x108,0x10C with matching instr_pc, no bubbles.
REQ-033 Backpressure: instr_ready=0, pc_valid=1 continuously -> exactly 4 requests issued, pc_ready=0 thereafter; release instr_ready -> 4 entries drain in order, fetching resumes.
REQ-034 Flush: queue holding 2 entries plus one in flight, flush pulse -> next cycle instr_valid=0, pc_ready=1; new pc_in 0x200 appears 2 cycles later as sole entry.
REQ-035 Misaligned: pc_in=0x6 -> imem_addr=0x4; entry instr=0x00000013, instr_pc=0x6, instr_misaligned=1.
REQ-036 Wrap and simultaneity: 10 fetches with instr_ready toggling every cycle -> all 10 delivered once, in order, count stays 0..4.
REQ-037 Async reset: assert reset between clock edges with 3 entries queued -> instr_valid=0 and pc_ready=0 immediately, pc_ready=1 first cycle after release.
